spike_window_classifier: RTL and testbench
==========================================

// Module: spike_window_classifier
// PURPOSE
//   Downstream consumer of the neuron layer's 1-bit spike outputs.
//   Counts spikes per neuron over a fixed window of clock cycles, then
//   picks the neuron with the highest count as the classification result.
//   Presents the result on a valid/ready output handshake.
// PARAMETERS
//   N_NEURONS  2    number of spike inputs (one per neuron); must be >= 2
//   WINDOW     64   window length in clock cycles; must be >= 1
//   CNT_W      8    per-neuron counter width; counters saturate at 2^CNT_W-1
//   IDX_W      $clog2(N_NEURONS)   width of the winner index (localparam)
// PORTS
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous, active-low reset
//   start         in   1          request a new window; sampled only in IDLE
//   clear         in   1          synchronous abort, accepted in any state
//   spike_in      in   N_NEURONS  spike bit i comes from neuron i
//   busy          out  1          high in COUNT and COMPARE
//   result_valid  out  1          result fields are valid (HOLD state)
//   result_ready  in   1          consumer accepts the result
//   winner_idx    out  IDX_W      index of the neuron with the maximum count
//   winner_cnt    out  CNT_W      spike count of the winner
//   tie           out  1          another neuron matched the max count
//   no_spike      out  1          all counts are zero
// BEHAVIOUR
//   Reset: state=IDLE; all counters, busy, result_valid, winner_idx,
//     winner_cnt, tie and no_spike are 0.
//   FSM states: IDLE -> COUNT -> COMPARE -> HOLD -> IDLE.
//   IDLE: if start=1 at edge t, zero all counters and go to COUNT.
//     start is ignored in every other state.
//   COUNT: spike_in is sampled on exactly WINDOW edges, t+1..t+WINDOW.
//     On each edge, counter i increments when spike_in[i]=1.
//     A counter at 2^CNT_W-1 holds (saturates) and does not wrap.
//     The window cycle counter reaches WINDOW-1 on the last sampling
//     edge; the FSM then goes to COMPARE.
//   COMPARE: a sequential argmax, one neuron per cycle, N_NEURONS cycles.
//     The first cycle loads neuron 0 as the running best.
//     For i>0: count_i > best replaces the best and clears tie.
//     count_i == best sets tie and keeps the lower index.
//     After neuron N-1, winner_idx, winner_cnt, tie and
//     no_spike=(winner_cnt==0) are registered.
//     no_spike=1 forces winner_idx=0, tie=0.
//   HOLD: result_valid=1 from edge t+WINDOW+N_NEURONS onward.
//     All result fields stay stable while result_valid=1 and
//     result_ready=0.
//     On an edge with result_valid & result_ready: go to IDLE and
//     deassert result_valid on that edge. A start in that same cycle is
//     ignored (not IDLE yet), so back-to-back windows are separated by
//     at least one IDLE cycle.
//   Result fields keep their last values in IDLE; they are meaningful only
//     when result_valid=1.
//   clear=1: go to IDLE on the next edge from any state and zero the
//     counters and result_valid. Result fields keep their values.
//     clear has priority over start and over the handshake.
//   Reset asserted mid-window: immediate return to reset values; the
//     partial window is discarded.
//   busy=1 exactly in COUNT and COMPARE (WINDOW+N_NEURONS cycles).
// TESTING
//   1 N=2,W=64: spike_in=2'b10 every cycle, ready=1 -> idx=1, cnt=64,
//     tie=0, valid high 1 cycle at t+66.
//   2 Equal counts (both neurons 10 spikes) -> idx=0, cnt=10, tie=1.
//   3 No spikes -> no_spike=1, idx=0, cnt=0, tie=0.
//   4 CNT_W=4, W=64, neuron0 always spiking -> cnt=15 (saturated, no wrap).
//   5 ready held low 20 cycles in HOLD -> valid and fields stable; ready=1
//     -> IDLE next edge; start in the handshake cycle is ignored.
//   6 clear at window cycle 30, and rst_n low mid-COUNT -> IDLE, valid=0,
//     a new start gives counts from the fresh window only.

Source files
------------

// File: rtl/spike_window_classifier_if.sv
// Handshake/result bundle between a spike window classifier and its driver/consumer.
// Instances must use the same N_NEURONS and CNT_W as the classifier they connect to.
interface spike_window_classifier_if #(
  parameter int N_NEURONS = 2,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = $clog2(N_NEURONS)
);
  logic                 start;
  logic                 clear;
  logic [N_NEURONS-1:0] spike_in;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic [IDX_W-1:0]     winner_idx;
  logic [CNT_W-1:0]     winner_cnt;
  logic                 tie;
  logic                 no_spike;

  modport master (
    output start, clear, spike_in, result_ready,
    input  busy, result_valid, winner_idx, winner_cnt, tie, no_spike
  );
  modport slave (
    input  start, clear, spike_in, result_ready,
    output busy, result_valid, winner_idx, winner_cnt, tie, no_spike
  );
endinterface

// File: rtl/spike_window_classifier.sv
// Counts spikes per neuron over a fixed window, then runs a sequential argmax
// (one neuron per cycle) and presents the winner on a valid/ready handshake.
module swc_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zero,
  input  logic             en,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        cnt <= '0;
    else if (zero)                                     cnt <= '0;
    else if (en && spike && (cnt != {CNT_W{1'b1}}))    cnt <= cnt + CNT_W'(1);
  end
endmodule

module spike_window_classifier #(
  parameter int N_NEURONS = 2,
  parameter int WINDOW    = 64,
  parameter int CNT_W     = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  spike_window_classifier_if.slave bus
);
  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int WIN_W = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, COUNT, COMPARE, HOLD} state_t;
  state_t state, nstate;

  logic [N_NEURONS-1:0][CNT_W-1:0] cnt;
  logic [WIN_W-1:0]                wcnt;
  logic [IDX_W-1:0]                ci, best_idx, nb_idx;
  logic [CNT_W-1:0]                best_cnt, nb_cnt, cur;
  logic                            best_tie, nb_tie;
  logic                            zero, en, last_win, last_n, finish;
  logic                            rvalid, r_tie, r_ns;
  logic [IDX_W-1:0]                r_idx;
  logic [CNT_W-1:0]                r_cnt;

  assign zero     = bus.clear | ((state == IDLE) & bus.start);
  assign en       = (state == COUNT);
  assign last_win = (wcnt == WIN_W'(WINDOW - 1));
  assign last_n   = (ci == IDX_W'(N_NEURONS - 1));
  assign finish   = (state == COMPARE) & last_n & ~bus.clear;

  genvar g;
  generate
    for (g = 0; g < N_NEURONS; g++) begin : g_lane
      swc_lane #(.CNT_W(CNT_W)) u_lane (
        .clk(clk), .rst_n(rst_n), .zero(zero), .en(en),
        .spike(bus.spike_in[g]), .cnt(cnt[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (bus.clear) nstate = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.start)        nstate = COUNT;
        COUNT:   if (last_win)         nstate = COMPARE;
        COMPARE: if (last_n)           nstate = HOLD;
        HOLD:    if (bus.result_ready) nstate = IDLE;
        default:                       nstate = IDLE;
      endcase
    end
  end

  // Running argmax step; equal counts keep the lower index and flag a tie.
  always_comb begin
    cur    = cnt[ci];
    nb_cnt = best_cnt;
    nb_idx = best_idx;
    nb_tie = best_tie;
    if (ci == '0) begin
      nb_cnt = cur;
      nb_idx = '0;
      nb_tie = 1'b0;
    end else if (cur > best_cnt) begin
      nb_cnt = cur;
      nb_idx = ci;
      nb_tie = 1'b0;
    end else if (cur == best_cnt) begin
      nb_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      ci       <= '0;
      best_cnt <= '0;
      best_idx <= '0;
      best_tie <= 1'b0;
    end else begin
      wcnt <= (state == COUNT && !last_win) ? wcnt + WIN_W'(1) : '0;
      ci   <= (state == COMPARE && !last_n) ? ci + IDX_W'(1) : '0;
      if (state == COMPARE) begin
        best_cnt <= nb_cnt;
        best_idx <= nb_idx;
        best_tie <= nb_tie;
      end
    end
  end

  // Result fields only change when a comparison completes; clear drops valid only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_tie  <= 1'b0;
      r_ns   <= 1'b0;
    end else begin
      if (bus.clear)                                rvalid <= 1'b0;
      else if (finish)                              rvalid <= 1'b1;
      else if (state == HOLD && bus.result_ready)   rvalid <= 1'b0;
      if (finish) begin
        r_cnt <= nb_cnt;
        r_ns  <= (nb_cnt == '0);
        r_idx <= (nb_cnt == '0) ? '0 : nb_idx;
        r_tie <= (nb_cnt == '0) ? 1'b0 : nb_tie;
      end
    end
  end

  assign bus.busy         = (state == COUNT) || (state == COMPARE);
  assign bus.result_valid = rvalid;
  assign bus.winner_idx   = r_idx;
  assign bus.winner_cnt   = r_cnt;
  assign bus.tie          = r_tie;
  assign bus.no_spike     = r_ns;
endmodule

// File: tb/tb_spike_window_classifier.sv
// Directed bench: two classifier instances (N=2/CNT_W=8 and N=3/CNT_W=4),
// hand-computed results queued at issue time and checked by handshake monitors.
module tb_spike_window_classifier;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spike_window_classifier_if #(.N_NEURONS(2), .CNT_W(8)) b0();
  spike_window_classifier_if #(.N_NEURONS(3), .CNT_W(4)) b1();

  spike_window_classifier #(.N_NEURONS(2), .WINDOW(64), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  spike_window_classifier #(.N_NEURONS(3), .WINDOW(64), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));

  typedef struct {int idx; int cnt; bit tie; bit ns;} exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: result presented with no queued expectation (t=%0t)", nm, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (b0.result_valid === 1'b1 && b0.result_ready === 1'b1) begin
      if (q0.size() == 0) unexpected("d0_unexpected");
      else begin
        e = q0.pop_front();
        chk("d0_idx", int'(b0.winner_idx), e.idx);
        chk("d0_cnt", int'(b0.winner_cnt), e.cnt);
        chk("d0_tie", int'(b0.tie), int'(e.tie));
        chk("d0_nospike", int'(b0.no_spike), int'(e.ns));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.result_valid === 1'b1 && b1.result_ready === 1'b1) begin
      if (q1.size() == 0) unexpected("d1_unexpected");
      else begin
        e = q1.pop_front();
        chk("d1_idx", int'(b1.winner_idx), e.idx);
        chk("d1_cnt", int'(b1.winner_cnt), e.cnt);
        chk("d1_tie", int'(b1.tie), int'(e.tie));
        chk("d1_nospike", int'(b1.no_spike), int'(e.ns));
      end
    end
  end

  // Neuron i spikes on the first k_i sampled cycles of the window.
  task automatic win0(input int k0, input int k1, input int ncyc);
    @(posedge clk); #1; b0.start = 1'b1;
    @(posedge clk); #1; b0.start = 1'b0;
    for (int j = 0; j < ncyc; j++) begin
      b0.spike_in = {(j < k1), (j < k0)};
      if (j == 10) chk("d0_busy_count", int'(b0.busy), 1);
      @(posedge clk); #1;
    end
    b0.spike_in = '0;
  endtask

  task automatic win1(input int k0, input int k1, input int k2);
    @(posedge clk); #1; b1.start = 1'b1;
    @(posedge clk); #1; b1.start = 1'b0;
    for (int j = 0; j < 64; j++) begin
      b1.spike_in = {(j < k2), (j < k1), (j < k0)};
      @(posedge clk); #1;
    end
    b1.spike_in = '0;
  endtask

  // After the window: COMPARE for N cycles, valid for exactly one cycle with ready=1.
  task automatic fin0();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("d0_valid_cmp", int'(b0.result_valid), 0);
      chk("d0_busy_cmp", int'(b0.busy), 1);
    end
    @(negedge clk);
    chk("d0_valid_hold", int'(b0.result_valid), 1);
    chk("d0_busy_hold", int'(b0.busy), 0);
    @(negedge clk);
    chk("d0_valid_drop", int'(b0.result_valid), 0);
  endtask

  task automatic fin1();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("d1_valid_cmp", int'(b1.result_valid), 0);
    end
    @(negedge clk);
    chk("d1_valid_hold", int'(b1.result_valid), 1);
    @(negedge clk);
    chk("d1_valid_drop", int'(b1.result_valid), 0);
  endtask

  initial begin
    b0.start = 0; b0.clear = 0; b0.spike_in = '0; b0.result_ready = 1;
    b1.start = 0; b1.clear = 0; b1.spike_in = '0; b1.result_ready = 1;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(b0.busy), 0);
    chk("rst_valid", int'(b0.result_valid), 0);
    chk("rst_idx", int'(b0.winner_idx), 0);
    chk("rst_cnt", int'(b0.winner_cnt), 0);
    chk("rst_tie", int'(b0.tie), 0);
    chk("rst_nospike", int'(b0.no_spike), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Neuron 1 every cycle, neuron 0 silent
    q0.push_back('{1, 64, 1'b0, 1'b0}); win0(0, 64, 64); fin0();
    // Equal counts keep the lower index
    q0.push_back('{0, 10, 1'b1, 1'b0}); win0(10, 10, 64); fin0();
    // Silent window
    q0.push_back('{0, 0, 1'b0, 1'b1}); win0(0, 0, 64); fin0();
    q0.push_back('{1, 9, 1'b0, 1'b0}); win0(5, 9, 64); fin0();

    // Back-pressure: result held stable, start in the handshake cycle ignored
    b0.result_ready = 1'b0;
    q0.push_back('{1, 30, 1'b0, 1'b0}); win0(0, 30, 64);
    repeat (2) begin @(negedge clk); chk("bp_valid_cmp", int'(b0.result_valid), 0); end
    repeat (21) begin
      @(negedge clk);
      chk("bp_valid", int'(b0.result_valid), 1);
      chk("bp_idx", int'(b0.winner_idx), 1);
      chk("bp_cnt", int'(b0.winner_cnt), 30);
      chk("bp_tie", int'(b0.tie), 0);
    end
    @(posedge clk); #1; b0.result_ready = 1'b1; b0.start = 1'b1;
    @(posedge clk); #1; b0.start = 1'b0;
    chk("hs_valid_drop", int'(b0.result_valid), 0);
    chk("hs_start_ignored", int'(b0.busy), 0);
    @(negedge clk);
    chk("hs_still_idle", int'(b0.busy), 0);

    // Clear at window cycle 30, then a fresh window
    win0(40, 40, 30);
    b0.clear = 1'b1;
    @(posedge clk); #1; b0.clear = 1'b0;
    chk("clr_busy", int'(b0.busy), 0);
    chk("clr_valid", int'(b0.result_valid), 0);
    q0.push_back('{1, 7, 1'b0, 1'b0}); win0(5, 7, 64); fin0();

    // Clear in HOLD drops valid but keeps result fields
    b0.result_ready = 1'b0;
    win0(3, 3, 64);
    repeat (3) @(negedge clk);
    chk("clrh_valid_before", int'(b0.result_valid), 1);
    @(posedge clk); #1; b0.clear = 1'b1;
    @(posedge clk); #1; b0.clear = 1'b0;
    chk("clrh_valid", int'(b0.result_valid), 0);
    chk("clrh_cnt_kept", int'(b0.winner_cnt), 3);
    chk("clrh_tie_kept", int'(b0.tie), 1);
    b0.result_ready = 1'b1;

    // Reset mid-COUNT, then a fresh window
    win0(50, 50, 20);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", int'(b0.busy), 0);
    chk("mrst_valid", int'(b0.result_valid), 0);
    chk("mrst_cnt", int'(b0.winner_cnt), 0);
    chk("mrst_tie", int'(b0.tie), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    q0.push_back('{0, 3, 1'b0, 1'b0}); win0(3, 2, 64); fin0();

    // Narrow counters: saturation at 15
    q1.push_back('{0, 15, 1'b0, 1'b0}); win1(64, 0, 0); fin1();
    q1.push_back('{1, 15, 1'b1, 1'b0}); win1(0, 20, 64); fin1();
    q1.push_back('{2, 6, 1'b0, 1'b0}); win1(4, 4, 6); fin1();
    q1.push_back('{2, 5, 1'b0, 1'b0}); win1(0, 3, 5); fin1();

    @(negedge clk);
    chk("d0_queue_drained", q0.size(), 0);
    chk("d1_queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
